// File: rtl/color_pkg.sv
// Shared color metric definitions for the highlight filter and blob tracker.
// Channel encoding, threshold, score width and tracker FSM states.
package color_pkg;

  typedef enum logic [1:0] {
    CH_R    = 2'b00,
    CH_G    = 2'b01,
    CH_B    = 2'b10,
    CH_NONE = 2'b11
  } ch_t;

  localparam logic [24:0] THRESH_DEF = 25'd82906;
  localparam int          SCORE_W    = 26;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_FLUSH,
    ST_PUBLISH
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       tag;
    logic [9:0] x;
    logic [9:0] y;
  } px_t;

endpackage

// File: rtl/color_score.sv
// Two-stage dominance score: register channel differences, then the
// signed product compared against the threshold, with position carried along.
module color_score
  import color_pkg::*;
#(
  parameter logic [24:0] THRESH = THRESH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid,
  input  ch_t        sel,
  input  logic [7:0] r,
  input  logic [7:0] g,
  input  logic [7:0] b,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       tag,
  output logic       match,
  output px_t        px
);

  logic [7:0] c, a, o;

  always_comb begin
    c = r;
    a = g;
    o = b;
    unique case (sel)
      CH_G: begin
        c = g;
        a = r;
        o = b;
      end
      CH_B: begin
        c = b;
        a = r;
        o = g;
      end
      default: ;
    endcase
  end

  px_t               s1_px;
  logic [7:0]        s1_c;
  logic signed [8:0] s1_da, s1_db;
  logic              s1_none;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_px   <= '0;
      s1_c    <= '0;
      s1_da   <= '0;
      s1_db   <= '0;
      s1_none <= 1'b1;
    end else begin
      s1_px   <= '{valid: valid, tag: tag, x: x, y: y};
      s1_c    <= c;
      s1_da   <= $signed({1'b0, c}) - $signed({1'b0, a});
      s1_db   <= $signed({1'b0, c}) - $signed({1'b0, o});
      s1_none <= (sel == CH_NONE);
    end
  end

  // Full 26-bit product: unlike the display path, nothing is truncated.
  logic signed [SCORE_W-1:0] ce, ae, oe, prod, th;

  always_comb begin
    ce   = {{(SCORE_W-8){1'b0}}, s1_c};
    ae   = {{(SCORE_W-9){s1_da[8]}}, s1_da};
    oe   = {{(SCORE_W-9){s1_db[8]}}, s1_db};
    th   = {{(SCORE_W-25){THRESH[24]}}, THRESH};
    prod = ce * ae * oe;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      px    <= '0;
      match <= 1'b0;
    end else begin
      px    <= s1_px;
      match <= s1_px.valid & ~s1_none & (prod > th);
    end
  end

endmodule

// File: rtl/color_blob_tracker.sv
// Per-frame bounding box and count of pixels dominated by one channel,
// published once per frame on a valid/ready result port.
module color_blob_tracker
  import color_pkg::*;
#(
  parameter int          H_RES  = 640,
  parameter int          V_RES  = 480,
  parameter logic [24:0] THRESH = THRESH_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ctrl,
  input  logic        in_valid,
  input  logic        in_sof,
  input  logic        in_eol,
  input  logic [7:0]  in_r,
  input  logic [7:0]  in_g,
  input  logic [7:0]  in_b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_found,
  output logic [9:0]  out_xmin,
  output logic [9:0]  out_xmax,
  output logic [9:0]  out_ymin,
  output logic [9:0]  out_ymax,
  output logic [18:0] out_count,
  output logic        out_overrun
);

  if (H_RES > 1024 || V_RES > 1024) begin : g_res_check
    $error("resolution exceeds 10-bit coordinates");
  end

  localparam logic [9:0] YLAST = 10'(V_RES - 1);

  state_t     state;
  logic       fl_cnt;
  logic       in_frame;
  logic       tag_q;
  ch_t        ctrl_q;
  logic [9:0] x_q, y_q;

  logic       acc_px, last_px, frame_nx, xfer, ptag;
  logic [9:0] xp, yp;
  ch_t        sel;

  always_comb begin
    acc_px   = in_valid & (in_sof | in_frame);
    xp       = in_sof ? 10'd0 : x_q;
    yp       = in_sof ? 10'd0 : y_q;
    last_px  = acc_px & in_eol & (yp == YLAST);
    frame_nx = acc_px ? ~last_px : in_frame;
    sel      = in_sof ? ch_t'(ctrl) : ctrl_q;
    ptag     = in_sof ? ~tag_q : tag_q;
    xfer     = out_valid & out_ready;
  end

  logic match;
  px_t  spx;

  color_score #(.THRESH(THRESH)) u_score (
    .clk   (clk),
    .rst   (rst),
    .valid (acc_px),
    .sel   (sel),
    .r     (in_r),
    .g     (in_g),
    .b     (in_b),
    .x     (xp),
    .y     (yp),
    .tag   (ptag),
    .match (match),
    .px    (spx)
  );

  logic        acc_tag;
  logic [9:0]  acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  logic [18:0] acc_count;

  // A tag change marks the first pixel of a new frame: restart from it.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_tag   <= 1'b0;
      acc_xmin  <= '1;
      acc_xmax  <= '0;
      acc_ymin  <= '1;
      acc_ymax  <= '0;
      acc_count <= '0;
    end else if (spx.valid) begin
      if (spx.tag != acc_tag) begin
        acc_tag   <= spx.tag;
        acc_xmin  <= match ? spx.x : '1;
        acc_xmax  <= match ? spx.x : '0;
        acc_ymin  <= match ? spx.y : '1;
        acc_ymax  <= match ? spx.y : '0;
        acc_count <= match ? 19'd1 : 19'd0;
      end else if (match) begin
        if (spx.x < acc_xmin) acc_xmin <= spx.x;
        if (spx.x > acc_xmax) acc_xmax <= spx.x;
        if (spx.y < acc_ymin) acc_ymin <= spx.y;
        if (spx.y > acc_ymax) acc_ymax <= spx.y;
        if (acc_count != '1) acc_count <= acc_count + 19'd1;
      end
    end
  end

  logic found;
  assign found = (acc_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      fl_cnt      <= 1'b0;
      in_frame    <= 1'b0;
      tag_q       <= 1'b0;
      ctrl_q      <= CH_R;
      x_q         <= '0;
      y_q         <= '0;
      out_valid   <= 1'b0;
      out_found   <= 1'b0;
      out_xmin    <= '0;
      out_xmax    <= '0;
      out_ymin    <= '0;
      out_ymax    <= '0;
      out_count   <= '0;
      out_overrun <= 1'b0;
    end else begin
      in_frame <= frame_nx;
      if (acc_px) begin
        if (in_sof) begin
          ctrl_q <= ch_t'(ctrl);
          tag_q  <= ~tag_q;
        end
        if (in_eol) begin
          x_q <= '0;
          y_q <= yp + 10'd1;
        end else begin
          x_q <= (xp == 10'd1023) ? xp : xp + 10'd1;
          y_q <= yp;
        end
      end

      unique case (state)
        ST_IDLE, ST_ACTIVE: begin
          fl_cnt <= 1'b0;
          if (last_px) state <= ST_FLUSH;
          else if (acc_px) state <= ST_ACTIVE;
        end
        ST_FLUSH: begin
          fl_cnt <= ~fl_cnt;
          if (fl_cnt) state <= ST_PUBLISH;
        end
        ST_PUBLISH: begin
          state <= frame_nx ? ST_ACTIVE : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (state == ST_PUBLISH) begin
        out_valid   <= 1'b1;
        out_overrun <= out_valid & ~out_ready;
        out_found   <= found;
        out_xmin    <= found ? acc_xmin : '0;
        out_xmax    <= found ? acc_xmax : '0;
        out_ymin    <= found ? acc_ymin : '0;
        out_ymax    <= found ? acc_ymax : '0;
        out_count   <= acc_count;
      end else if (xfer) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_color_blob_tracker.sv
// Directed bench for color_blob_tracker on a 4x2 frame: score boundaries,
// channel select, latency, overrun, abort, reset in flush, x saturation.
module tb_color_blob_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  ctrl;
  logic        in_valid, in_sof, in_eol;
  logic [7:0]  in_r, in_g, in_b;
  logic        out_valid, out_ready, out_found, out_overrun;
  logic [9:0]  out_xmin, out_xmax, out_ymin, out_ymax;
  logic [18:0] out_count;

  always #5 clk = ~clk;

  color_blob_tracker #(.H_RES(4), .V_RES(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .ctrl        (ctrl),
    .in_valid    (in_valid),
    .in_sof      (in_sof),
    .in_eol      (in_eol),
    .in_r        (in_r),
    .in_g        (in_g),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_found   (out_found),
    .out_xmin    (out_xmin),
    .out_xmax    (out_xmax),
    .out_ymin    (out_ymin),
    .out_ymax    (out_ymax),
    .out_count   (out_count),
    .out_overrun (out_overrun)
  );

  typedef struct {
    int r, g, b, c, sx, sy, all;
    int found, xmin, xmax, ymin, ymax, count;
  } vec_t;

  vec_t vt[11];
  int   n_chk = 0;
  int   n_fail = 0;
  int   cur = -1;
  int   lat;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s (case %0d): got %0d expected %0d", nm, cur, act, exp);
    end
  endtask

  task automatic pix(input int r, g, b, input logic sof, eol);
    @(negedge clk);
    in_valid = 1'b1;
    in_r = 8'(r);
    in_g = 8'(g);
    in_b = 8'(b);
    in_sof = sof;
    in_eol = eol;
  endtask

  task automatic send_frame(input int r, g, b, c, sx, sy, all, w);
    ctrl = 2'(c);
    for (int yy = 0; yy < 2; yy++) begin
      for (int xx = 0; xx < ((yy == 0) ? w : 4); xx++) begin
        if (all != 0 || (xx == sx && yy == sy))
          pix(r, g, b, (xx == 0 && yy == 0), (xx == ((yy == 0) ? w : 4) - 1));
        else
          pix(50, 50, 50, (xx == 0 && yy == 0), (xx == ((yy == 0) ? w : 4) - 1));
      end
    end
  endtask

  task automatic wait_valid(output int l);
    l = 0;
    do begin
      @(negedge clk);
      in_valid = 1'b0;
      l++;
    end while (!out_valid && l < 40);
    chk("timeout", out_valid, 1);
  endtask

  task automatic check_res(input int f, x0, x1, y0, y1, c, ov);
    chk("found", out_found, f);
    chk("xmin", out_xmin, x0);
    chk("xmax", out_xmax, x1);
    chk("ymin", out_ymin, y0);
    chk("ymax", out_ymax, y1);
    chk("count", out_count, c);
    chk("overrun", out_overrun, ov);
  endtask

  task automatic accept();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("valid_drop", out_valid, 0);
  endtask

  initial begin
    vt[0]  = '{200, 10, 10, 0, 2, 1, 0, 1, 2, 2, 1, 1, 1};
    vt[1]  = '{86, 33, 33, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
    vt[2]  = '{44, 1, 0, 0, 3, 1, 0, 1, 3, 3, 1, 1, 1};
    vt[3]  = '{43, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    vt[4]  = '{100, 150, 50, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0};
    vt[5]  = '{10, 200, 10, 1, 3, 0, 0, 1, 3, 3, 0, 0, 1};
    vt[6]  = '{10, 10, 200, 2, 0, 1, 0, 1, 0, 0, 1, 1, 1};
    vt[7]  = '{200, 10, 10, 3, 2, 1, 0, 0, 0, 0, 0, 0, 0};
    vt[8]  = '{200, 10, 10, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0};
    vt[9]  = '{200, 10, 10, 0, 0, 0, 1, 1, 0, 3, 0, 1, 8};
    vt[10] = '{10, 200, 200, 0, 1, 0, 0, 1, 1, 1, 0, 0, 1};

    rst = 1'b1;
    ctrl = 2'b00;
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_eol = 1'b0;
    in_r = '0;
    in_g = '0;
    in_b = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", out_valid, 0);
    check_res(0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 11; i++) begin
      cur = i;
      send_frame(vt[i].r, vt[i].g, vt[i].b, vt[i].c, vt[i].sx, vt[i].sy, vt[i].all, 4);
      wait_valid(lat);
      chk("latency", lat, 4);
      check_res(vt[i].found, vt[i].xmin, vt[i].xmax, vt[i].ymin, vt[i].ymax,
                vt[i].count, 0);
      accept();
      repeat (2) @(negedge clk);
    end

    // back-to-back frames: second sof right after the final pixel
    cur = 100;
    send_frame(200, 10, 10, 0, 0, 0, 0, 4);
    send_frame(200, 10, 10, 0, 3, 1, 0, 4);
    chk("b2b_valid_a", out_valid, 1);
    chk("b2b_xmin_a", out_xmin, 0);
    chk("b2b_count_a", out_count, 1);
    accept();
    wait_valid(lat);
    check_res(1, 3, 3, 1, 1, 1, 0);
    accept();

    // overrun: two results without ready
    cur = 101;
    send_frame(200, 10, 10, 0, 2, 1, 0, 4);
    wait_valid(lat);
    check_res(1, 2, 2, 1, 1, 1, 0);
    send_frame(200, 10, 10, 0, 0, 0, 1, 4);
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    chk("hold_valid", out_valid, 1);
    chk("hold_count", out_count, 1);
    @(negedge clk);
    check_res(1, 0, 3, 0, 1, 8, 1);
    accept();
    repeat (3) @(negedge clk);
    chk("no_retransfer", out_valid, 0);

    // abort mid-frame after 3 matching pixels
    cur = 102;
    ctrl = 2'b00;
    pix(200, 10, 10, 1'b1, 1'b0);
    pix(200, 10, 10, 1'b0, 1'b0);
    pix(200, 10, 10, 1'b0, 1'b0);
    send_frame(200, 10, 10, 0, 1, 1, 0, 4);
    chk("abort_no_result", out_valid, 0);
    wait_valid(lat);
    chk("abort_latency", lat, 4);
    check_res(1, 1, 1, 1, 1, 1, 0);
    accept();

    // reset during flush
    cur = 103;
    send_frame(200, 10, 10, 0, 0, 0, 1, 4);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rst_flush_valid", out_valid, 0);
    end
    check_res(0, 0, 0, 0, 0, 0, 0);
    send_frame(200, 10, 10, 0, 2, 1, 0, 4);
    wait_valid(lat);
    chk("post_rst_latency", lat, 4);
    check_res(1, 2, 2, 1, 1, 1, 0);
    accept();

    // overlong first line: x saturates at 1023
    cur = 104;
    send_frame(200, 10, 10, 0, 1029, 0, 0, 1030);
    wait_valid(lat);
    chk("sat_latency", lat, 4);
    check_res(1, 1023, 1023, 0, 0, 1, 0);
    accept();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
